// File: rtl/icache_responder_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_types;

  localparam int unsigned S_OFFSET       = 5;
  localparam int unsigned S_INDEX        = 3;
  localparam int unsigned S_TAG          = 32 - S_OFFSET - S_INDEX;
  localparam int unsigned NUM_SETS       = 1 << S_INDEX;
  localparam int unsigned WORDS_PER_LINE = (1 << S_OFFSET) / 4;
  localparam int unsigned LINE_W         = 8 << S_OFFSET;

  typedef enum logic {S_IDLE, S_FETCH} icache_state_t;

  typedef logic [255:0]         line_t;
  typedef logic [S_TAG-1:0]     tag_t;
  typedef logic [S_INDEX-1:0]   idx_t;
  typedef logic [S_OFFSET-3:0]  word_sel_t;

  // Word w of a line lives at bits [32w+31:32w].
  function automatic logic [31:0] line_word(input line_t line, input word_sel_t w);
    return line[32*w +: 32];
  endfunction

endpackage

// File: rtl/icache_responder_array.sv
// Valid/tag/data storage: one write port, combinational read by index.
module icache_array #(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned TAG_W  = 24,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [LINE_W-1:0] wline,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [LINE_W-1:0] rline
);

  localparam int unsigned SETS = 1 << IDX_W;

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];

  // Valid bits clear asynchronously; a refill marks its set valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (load) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and data storage is never reset; valid gates its use.
  always_ff @(posedge clk) begin
    if (load) begin
      tags[widx]  <= wtag;
      lines[widx] <= wline;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rline  = lines[ridx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-line refill on miss.
module icache_responder
  import icache_types::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         inst_read,
  input  logic [31:0]  inst_addr,
  output logic [31:0]  inst_rdata,
  output logic         inst_resp,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  icache_state_t state, state_next;

  tag_t       req_tag;
  idx_t       req_idx;
  word_sel_t  req_word;
  logic [31:0] miss_addr;

  logic  hit;
  logic  miss_start;
  logic  load;
  logic  arr_valid;
  tag_t  arr_tag;
  line_t arr_line;
  logic  unused_addr_bits;

  assign req_tag          = inst_addr[31 -: S_TAG];
  assign req_idx          = inst_addr[S_OFFSET +: S_INDEX];
  assign req_word         = inst_addr[S_OFFSET-1:2];
  assign unused_addr_bits = ^inst_addr[1:0];

  icache_array #(
    .IDX_W  (S_INDEX),
    .TAG_W  (S_TAG),
    .LINE_W (LINE_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .widx   (miss_addr[S_OFFSET +: S_INDEX]),
    .wtag   (miss_addr[31 -: S_TAG]),
    .wline  (pmem_rdata),
    .ridx   (req_idx),
    .rvalid (arr_valid),
    .rtag   (arr_tag),
    .rline  (arr_line)
  );

  assign hit = inst_read & arr_valid & (arr_tag == req_tag);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the line address of a miss; held stable for the whole fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_addr <= '0;
    end else if (miss_start) begin
      miss_addr <= {req_tag, req_idx, {S_OFFSET{1'b0}}};
    end
  end

  // Next-state, hit response and memory handshake.
  always_comb begin
    state_next   = state;
    inst_resp    = 1'b0;
    inst_rdata   = '0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    load         = 1'b0;
    miss_start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          inst_resp  = 1'b1;
          inst_rdata = line_word(arr_line, req_word);
        end else if (inst_read) begin
          miss_start = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = miss_addr;
        if (pmem_resp) begin
          load       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a response scoreboard.
module tb_icache_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         inst_read;
  logic [31:0]  inst_addr;
  logic [31:0]  inst_rdata;
  logic         inst_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  icache_responder dut (
    .clk          (clk),
    .reset        (reset),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_resp    (inst_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  // Backing-memory contents: each word is its own aligned address scrambled.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = {a[31:5], 5'b0};
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word(base + 32'(4*w));
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response must match the oldest expected one.
  always @(negedge clk) begin
    if (inst_resp === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got inst_resp=1 at addr %h expected no response", inst_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", inst_rdata, e.data);
        chk("resp_addr", inst_addr, e.addr);
      end
    end
  end

  // Hit: answered in the request cycle, no memory traffic.
  task automatic do_hit(input logic [31:0] a);
    inst_read = 1'b1;
    inst_addr = a;
    sb.push_back('{addr: a, data: mem_word(a)});
    step();
    chk("hit_no_pmem_read", 32'(pmem_read), 32'd0);
    chk("hit_drain", 32'(sb.size()), 32'd0);
  endtask

  // Miss: fetch begins next cycle, memory answers after lat cycles,
  // response follows the cycle after pmem_resp.
  task automatic do_miss(input logic [31:0] a, input int lat);
    inst_read = 1'b1;
    inst_addr = a;
    step();
    chk("miss_pmem_read", 32'(pmem_read), 32'd1);
    chk("miss_pmem_address", pmem_address, {a[31:5], 5'b0});
    repeat (lat - 1) step();
    chk("miss_pmem_address_held", pmem_address, {a[31:5], 5'b0});
    pmem_rdata = mem_line(a);
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    sb.push_back('{addr: a, data: mem_word(a)});
    chk("refill_pmem_read_low", 32'(pmem_read), 32'd0);
    step();
    chk("miss_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    inst_read  = 1'b1;
    inst_addr  = 32'h6000_0000;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #12;
    chk("reset_inst_resp", 32'(inst_resp), 32'd0);
    chk("reset_inst_rdata", inst_rdata, 32'd0);
    chk("reset_pmem_read", 32'(pmem_read), 32'd0);
    chk("reset_pmem_address", pmem_address, 32'd0);
    inst_read = 1'b0;
    step();
    reset = 1'b0;
    step();

    // 1: cold miss
    do_miss(32'h6000_0000, 3);

    // 2: streaming hits across the rest of the line
    for (int w = 1; w < 8; w++) do_hit(32'h6000_0000 + 32'(4*w));

    // 3: conflict eviction on set 0
    do_miss(32'h6000_0100, 2);
    do_miss(32'h6000_0000, 4);

    // 4: address change mid-fetch; original line still filled
    inst_read = 1'b1;
    inst_addr = 32'h6000_0040;
    step();
    chk("chg_pmem_read", 32'(pmem_read), 32'd1);
    chk("chg_pmem_address", pmem_address, 32'h6000_0040);
    inst_addr = 32'h6000_0020;
    step();
    chk("chg_pmem_address_held", pmem_address, 32'h6000_0040);
    pmem_rdata = mem_line(32'h6000_0040);
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    step();
    chk("chg2_pmem_read", 32'(pmem_read), 32'd1);
    chk("chg2_pmem_address", pmem_address, 32'h6000_0020);
    pmem_rdata = mem_line(32'h6000_0020);
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    sb.push_back('{addr: 32'h6000_0020, data: mem_word(32'h6000_0020)});
    step();
    chk("chg2_drain", 32'(sb.size()), 32'd0);
    do_hit(32'h6000_0040);
    do_hit(32'h6000_005C);

    // top line of the address space
    do_miss(32'hFFFF_FFFC, 2);
    do_hit(32'hFFFF_FFE0);

    // 5: reset mid-fetch, then a stray pmem_resp
    inst_read = 1'b1;
    inst_addr = 32'h6000_0060;
    step();
    chk("rst_mid_pmem_read_before", 32'(pmem_read), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_pmem_read", 32'(pmem_read), 32'd0);
    chk("rst_mid_pmem_address", pmem_address, 32'd0);
    inst_read = 1'b0;
    step();
    reset = 1'b0;
    step();
    pmem_rdata = ~mem_line(32'h6000_0060);
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    do_miss(32'h6000_0000, 2);
    do_miss(32'h6000_0060, 3);

    // 6: stray response while idle with no request
    inst_read  = 1'b0;
    inst_addr  = 32'h6000_0000;
    pmem_rdata = '1;
    pmem_resp  = 1'b1;
    #1;
    chk("idle_inst_rdata", inst_rdata, 32'd0);
    chk("idle_inst_resp", 32'(inst_resp), 32'd0);
    step();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    do_hit(32'h6000_0000);
    do_hit(32'h6000_0007);
    do_hit(32'h6000_000B);

    inst_read = 1'b0;
    repeat (3) step();
    chk("final_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
